seg7_display_reader: RTL and testbench
======================================

// Module: seg7_display_reader
// PURPOSE
// - Reads back the 14-bit two-digit seven-segment bus driven by the ALU/decoder top level and recovers the displayed symbols.
// - Waits until the bus is stable, decodes each digit to a 4-bit value plus a status code, and reports each new reading over a valid/ready handshake.
// - Used as an on-chip monitor and as a bench-side checker of the display path.
// PARAMETERS
// - STABLE_CYCLES  4  consecutive unchanged cycles required before a reading is accepted. Legal range is 1..255.
// PORTS
// - clk        in   1   single system clock, rising edge
// - rst        in   1   synchronous, active-high reset
// - seg_in     in   14  [13:7] = high digit, [6:0] = low digit. Each digit is {a,b,c,d,e,f,g}, bit6 = a, active-high.
// - out_valid  out  1   a reading is being presented
// - out_ready  in   1   consumer accepts the reading
// - dig_hi     out  4   decoded value of the high digit
// - dig_lo     out  4   decoded value of the low digit
// - st_hi      out  2   status of the high digit: 00 hex, 01 blank, 10 minus, 11 illegal
// - st_lo      out  2   status of the low digit, same encoding as st_hi
// - out_ovr    out  1   the bus changed while the previous reading was still pending
// - err_cnt    out  8   count of illegal digits; see CONFIGURATION
// BEHAVIOUR
// - Digit decode table (pattern -> value):
//   - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7
//   - 7F->8, 7B->9, 77->A, 1F->b, 4E->C, 3D->d, 4F->E, 47->F
//   - 00 -> blank, value 0. 01 -> minus, value 0.
//   - Any other pattern -> illegal, value 0.
// - seg_in is registered into seg_q every cycle. "Changed" means seg_in != seg_q.
// - FSM states:
//   - SETTLE:
//     - Stability counter cnt clears on a change and increments while the bus is unchanged.
//     - When cnt reaches STABLE_CYCLES-1 with no change, compare seg_q against last_rep.
//     - If they differ, capture the decode into the output registers, load last_rep <= seg_q, and go to PRESENT.
//     - If they are equal, hold cnt and stay in SETTLE, so an identical pattern is never reported twice.
//   - PRESENT:
//     - out_valid = 1. dig_*, st_* and out_ovr are frozen.
//     - Any change on the bus in this state sets the internal ovr_pend flag.
//     - On out_valid & out_ready: out_valid drops on the next edge, cnt clears, and the FSM returns to SETTLE.
//     - out_ovr on the next reading = ovr_pend. ovr_pend clears when that reading is captured.
// - Latency: new pattern first presented before edge E0 and then held -> out_valid is high after edge E0+STABLE_CYCLES (STABLE_CYCLES+1 edges).
// - Once asserted, out_valid never drops without a handshake, except on rst.
// - out_ready high while out_valid is low has no effect.
// - A bus change on the same cycle as the handshake is captured by SETTLE normally. It does not set ovr_pend.
// - Reset values:
//   - out_valid=0, dig_*=0, st_*=01 (blank), out_ovr=0, err_cnt=0.
//   - cnt=0, ovr_pend=0, seg_q=0, last_rep=14'h0000.
//   - A blank display after reset is therefore not reported.
// - Reset mid-operation: rst has priority on the edge where it is sampled. Any pending reading is discarded and out_valid is low after that edge.
// CONFIGURATION
// - Macro: SEG7_READER_ERRCNT_EN.
// - Defined:
//   - err_cnt increments by the number of illegal digits (0, 1 or 2) in each captured reading.
//   - It saturates at 8'hFF and clears only on rst.
// - Undefined: err_cnt is tied to 8'h00 and no counter logic is built.
// TESTING (STABLE_CYCLES=4)
// - Reset, then hold seg_in=14'h0000 for 20 cycles -> out_valid stays 0 throughout.
// - Drive {7'h30,7'h6D} and hold, out_ready=1 -> after the 5th edge: out_valid=1, dig_hi=1, dig_lo=2, st_*=00. Exactly one handshake occurs.
// - Toggle seg_in every 3 cycles for 30 cycles, then hold {7'h01,7'h4F} -> no reading during the toggling, then exactly one reading with st_hi=10 and dig_lo=E.
// - Hold out_ready=0 while a reading is pending and change the bus to {7'h7E,7'h12} -> first reading is stable, out_ovr=0. After ready, the next reading has out_ovr=1, st_lo=11, dig_hi=0.
// - Repeat an illegal pattern reading 300 times with the macro defined -> err_cnt=8'hFF. With the macro undefined -> err_cnt=0.
// - Assert rst while out_valid=1 -> out_valid=0 after that edge and all outputs at their reset values.

Source files
------------

// File: rtl/seg7_display_reader.sv
`default_nettype none
// ============================================================================
// Module      : seg7_display_reader
// Description : Monitors a two-digit seven-segment bus, waits for it to settle,
//               decodes each digit and reports new readings over valid/ready.
//               Optional illegal-digit counter: define SEG7_READER_ERRCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_display_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] seg_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  dig_hi,
    output logic [3:0]  dig_lo,
    output logic [1:0]  st_hi,
    output logic [1:0]  st_lo,
    output logic        out_ovr,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] C_CNT_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        S_SETTLE  = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t      r_state;
    logic [13:0] r_seg_q;
    logic [13:0] r_last_rep;
    logic [7:0]  r_cnt;
    logic        r_ovr_pend;
    logic        r_valid;
    logic [3:0]  r_dig_hi;
    logic [3:0]  r_dig_lo;
    logic [1:0]  r_st_hi;
    logic [1:0]  r_st_lo;
    logic        r_ovr;

    logic        w_changed;
    logic        w_capture;
    logic [5:0]  w_dec_hi;
    logic [5:0]  w_dec_lo;

    // Returns {status[1:0], value[3:0]}
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] v;
        case (p)
            7'h7E:   v = {2'b00, 4'h0};
            7'h30:   v = {2'b00, 4'h1};
            7'h6D:   v = {2'b00, 4'h2};
            7'h79:   v = {2'b00, 4'h3};
            7'h33:   v = {2'b00, 4'h4};
            7'h5B:   v = {2'b00, 4'h5};
            7'h5F:   v = {2'b00, 4'h6};
            7'h70:   v = {2'b00, 4'h7};
            7'h7F:   v = {2'b00, 4'h8};
            7'h7B:   v = {2'b00, 4'h9};
            7'h77:   v = {2'b00, 4'hA};
            7'h1F:   v = {2'b00, 4'hB};
            7'h4E:   v = {2'b00, 4'hC};
            7'h3D:   v = {2'b00, 4'hD};
            7'h4F:   v = {2'b00, 4'hE};
            7'h47:   v = {2'b00, 4'hF};
            7'h00:   v = {2'b01, 4'h0};
            7'h01:   v = {2'b10, 4'h0};
            default: v = {2'b11, 4'h0};
        endcase
        return v;
    endfunction

    assign w_changed = (seg_in != r_seg_q);
    assign w_dec_hi  = decode(r_seg_q[13:7]);
    assign w_dec_lo  = decode(r_seg_q[6:0]);
    // A settled pattern identical to the last report is never re-reported
    assign w_capture = (r_state == S_SETTLE) && !w_changed &&
                       (r_cnt == C_CNT_LAST) && (r_seg_q != r_last_rep);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_SETTLE;
            r_seg_q    <= 14'h0000;
            r_last_rep <= 14'h0000;
            r_cnt      <= 8'd0;
            r_ovr_pend <= 1'b0;
            r_valid    <= 1'b0;
            r_dig_hi   <= 4'h0;
            r_dig_lo   <= 4'h0;
            r_st_hi    <= 2'b01;
            r_st_lo    <= 2'b01;
            r_ovr      <= 1'b0;
        end else begin
            r_seg_q <= seg_in;
            case (r_state)
                S_SETTLE: begin
                    if (w_changed) begin
                        r_cnt <= 8'd0;
                    end else if (w_capture) begin
                        r_valid    <= 1'b1;
                        r_dig_hi   <= w_dec_hi[3:0];
                        r_dig_lo   <= w_dec_lo[3:0];
                        r_st_hi    <= w_dec_hi[5:4];
                        r_st_lo    <= w_dec_lo[5:4];
                        r_ovr      <= r_ovr_pend;
                        r_ovr_pend <= 1'b0;
                        r_last_rep <= r_seg_q;
                        r_state    <= S_PRESENT;
                    end else if (r_cnt != C_CNT_LAST) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_PRESENT: begin
                    // A change coinciding with the handshake belongs to the next reading
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_cnt   <= 8'd0;
                        r_state <= S_SETTLE;
                    end else if (w_changed) begin
                        r_ovr_pend <= 1'b1;
                    end
                end
                default: r_state <= S_SETTLE;
            endcase
        end
    end

`ifdef SEG7_READER_ERRCNT_EN
    logic [7:0] r_err_cnt;
    logic [1:0] w_ill_num;
    logic [8:0] w_err_sum;

    assign w_ill_num = {1'b0, (w_dec_hi[5:4] == 2'b11)} + {1'b0, (w_dec_lo[5:4] == 2'b11)};
    assign w_err_sum = {1'b0, r_err_cnt} + {7'b0, w_ill_num};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'h00;
        end else if (w_capture) begin
            r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

    assign out_valid = r_valid;
    assign dig_hi    = r_dig_hi;
    assign dig_lo    = r_dig_lo;
    assign st_hi     = r_st_hi;
    assign st_lo     = r_st_lo;
    assign out_ovr   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_display_reader
// Description : Directed self-checking bench for seg7_display_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_display_reader;

    logic        clk;
    logic        rst;
    logic [13:0] seg_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  dig_hi;
    logic [3:0]  dig_lo;
    logic [1:0]  st_hi;
    logic [1:0]  st_lo;
    logic        out_ovr;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    int err_exp = 0;

    seg7_display_reader #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dig_hi    (dig_hi),
        .dig_lo    (dig_lo),
        .st_hi     (st_hi),
        .st_lo     (st_lo),
        .out_ovr   (out_ovr),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until out_valid is seen high, at most max_cyc edges
    task automatic wait_valid(input int max_cyc, input string name);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: out_valid=%b required 1 within %0d cycles", name, out_valid, max_cyc);
        end
    endtask

    task automatic add_err(input int n);
`ifdef SEG7_READER_ERRCNT_EN
        err_exp = (err_exp + n > 255) ? 255 : err_exp + n;
`else
        err_exp = 0 * n;
`endif
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if ({out_valid, dig_hi, dig_lo, st_hi, st_lo, out_ovr, err_cnt} !==
            {1'b0, 4'h0, 4'h0, 2'b01, 2'b01, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL %s: v=%b hi=%h lo=%h sthi=%b stlo=%b ovr=%b err=%h required v=0 hi=0 lo=0 st=01/01 ovr=0 err=00",
                     name, out_valid, dig_hi, dig_lo, st_hi, st_lo, out_ovr, err_cnt);
        end
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1; seg_in = 14'h0000; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        check_reset_outputs("reset_state");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL blank_not_reported: valid cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_basic();
        int extra;
        seg_in = {7'h30, 7'h6D}; out_ready = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL basic_latency edge %0d: out_valid=%b required 0", e, out_valid);
            end
        end
        step();
        total++;
        if ({out_valid, dig_hi, dig_lo, st_hi, st_lo, out_ovr} !== {1'b1, 4'h1, 4'h2, 2'b00, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL basic_read: v=%b hi=%h lo=%h st=%b/%b ovr=%b required v=1 hi=1 lo=2 st=00/00 ovr=0",
                     out_valid, dig_hi, dig_lo, st_hi, st_lo, out_ovr);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid === 1'b1) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL basic_single_handshake: extra valid cycles=%0d required 0", extra);
        end
    endtask

    task automatic test_toggle();
        int seen;
        int hs;
        logic [3:0] cap_dhi, cap_dlo;
        logic [1:0] cap_shi, cap_slo;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) seg_in = ((i / 3) % 2 == 0) ? {7'h5B, 7'h5F} : {7'h70, 7'h7F};
            step();
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL toggle_no_read: valid cycles=%0d required 0", seen);
        end
        seg_in = {7'h01, 7'h4F};
        hs = 0;
        cap_dhi = 4'hX; cap_dlo = 4'hX; cap_shi = 2'bXX; cap_slo = 2'bXX;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid === 1'b1) begin
                hs++;
                cap_dhi = dig_hi; cap_dlo = dig_lo; cap_shi = st_hi; cap_slo = st_lo;
            end
        end
        total++;
        if (hs != 1) begin
            bad++;
            $display("FAIL toggle_one_read: readings=%0d required 1", hs);
        end
        total++;
        if ({cap_shi, cap_dhi, cap_slo, cap_dlo} !== {2'b10, 4'h0, 2'b00, 4'hE}) begin
            bad++;
            $display("FAIL toggle_values: sthi=%b hi=%h stlo=%b lo=%h required sthi=10 hi=0 stlo=00 lo=E",
                     cap_shi, cap_dhi, cap_slo, cap_dlo);
        end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        seg_in = {7'h77, 7'h1F};
        wait_valid(20, "ovr_first_wait");
        total++;
        if ({dig_hi, dig_lo, st_hi, st_lo, out_ovr} !== {4'hA, 4'hB, 2'b00, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL ovr_first: hi=%h lo=%h st=%b/%b ovr=%b required hi=A lo=B st=00/00 ovr=0",
                     dig_hi, dig_lo, st_hi, st_lo, out_ovr);
        end
        seg_in = {7'h7E, 7'h12};
        for (int i = 0; i < 8; i++) step();
        total++;
        if ({out_valid, dig_hi, dig_lo, out_ovr} !== {1'b1, 4'hA, 4'hB, 1'b0}) begin
            bad++;
            $display("FAIL ovr_frozen: v=%b hi=%h lo=%h ovr=%b required v=1 hi=A lo=B ovr=0",
                     out_valid, dig_hi, dig_lo, out_ovr);
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ovr_handshake_drop: out_valid=%b required 0", out_valid);
        end
        wait_valid(20, "ovr_second_wait");
        add_err(1);
        total++;
        if ({out_ovr, st_hi, dig_hi, st_lo, dig_lo, err_cnt} !==
            {1'b1, 2'b00, 4'h0, 2'b11, 4'h0, 8'(err_exp)}) begin
            bad++;
            $display("FAIL ovr_second: ovr=%b sthi=%b hi=%h stlo=%b lo=%h err=%h required ovr=1 sthi=00 hi=0 stlo=11 lo=0 err=%h",
                     out_ovr, st_hi, dig_hi, st_lo, dig_lo, err_cnt, 8'(err_exp));
        end
    endtask

    // Alternating illegal patterns; each new pattern lands on the handshake edge
    task automatic test_errcnt();
        int ovr_bad;
        ovr_bad = 0;
        out_ready = 1'b1;
        for (int r = 0; r < 300; r++) begin
            seg_in = (r % 2 == 0) ? {7'h12, 7'h12} : {7'h13, 7'h13};
            step();
            wait_valid(20, "err_wait");
            add_err(2);
            if (out_ovr !== 1'b0) ovr_bad++;
            if (r == 0) begin
                total++;
                if (err_cnt !== 8'(err_exp)) begin
                    bad++;
                    $display("FAIL err_first: err_cnt=%h required %h", err_cnt, 8'(err_exp));
                end
            end
        end
        total++;
        if (ovr_bad != 0) begin
            bad++;
            $display("FAIL back_to_back_no_ovr: readings with out_ovr=1: %0d required 0", ovr_bad);
        end
        total++;
        if (err_cnt !== 8'(err_exp)) begin
            bad++;
            $display("FAIL err_saturate: err_cnt=%h required %h", err_cnt, 8'(err_exp));
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        seg_in = {7'h30, 7'h30};
        step();
        wait_valid(20, "midrst_wait");
        rst = 1'b1;
        step();
        rst = 1'b0;
        err_exp = 0;
        check_reset_outputs("mid_reset");
    endtask

    initial begin
        rst = 1'b1; seg_in = 14'h0000; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_toggle();
        test_overrun();
        test_errcnt();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
